// File: rtl/mod_classify_sel.sv
// Modulation classifier: picks a candidate type from channel measurements, commits it after
// CONFIRM agreeing samples, and routes/scales the matching demod channel to the output.
module mod_classify_sel #(
    parameter int DW       = 10,
    parameter int OW       = 8,
    parameter int FW       = 16,
    parameter int CONFIRM  = 4,
    parameter int DC_TH    = 60,
    parameter int AM_PAPR  = 5,
    parameter int FM_PAPR  = 5,
    parameter int PSK_PAPR = 20,
    parameter int F1       = 1500,
    parameter int F2       = 2500,
    parameter int MA_LO    = 30,
    parameter int MA_HI    = 35
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          meas_valid,
    input  logic [7:0]    ask_dc_offset,
    input  logic [7:0]    ask_papr,
    input  logic [9:0]    fsk_papr,
    input  logic [7:0]    ma,
    input  logic [DW-1:0] ask_data,
    input  logic [DW-1:0] fsk_data,
    input  logic [DW-1:0] psk_data,
    input  logic [FW-1:0] ask_freq,
    input  logic [FW-1:0] fsk_freq,
    input  logic [FW-1:0] psk_freq,
    output logic [OW-1:0] demod_data,
    output logic [7:0]    mod_type,
    output logic [FW-1:0] demod_fre,
    output logic          type_chg,
    output logic          locked
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_AM   = 3'd1;
    localparam logic [2:0] T_ASK  = 3'd2;
    localparam logic [2:0] T_FM   = 3'd3;
    localparam logic [2:0] T_FSK  = 3'd4;
    localparam logic [2:0] T_PSK  = 3'd5;
    localparam logic [2:0] T_CW   = 3'd6;

    localparam logic [3:0]    CONF_W     = 4'(CONFIRM);
    localparam logic [7:0]    DC_TH_W    = 8'(DC_TH);
    localparam logic [7:0]    AM_PAPR_W  = 8'(AM_PAPR);
    localparam logic [9:0]    FM_PAPR_W  = 10'(FM_PAPR);
    localparam logic [9:0]    PSK_PAPR_W = 10'(PSK_PAPR);
    localparam logic [FW-1:0] F1_W       = FW'(F1);
    localparam logic [FW-1:0] F2_W       = FW'(F2);
    localparam logic [7:0]    MA_LO_W    = 8'(MA_LO);
    localparam logic [7:0]    MA_HI_W    = 8'(MA_HI);
    localparam logic [OW-1:0] MIDSCALE   = {1'b1, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_CONFIRM} state_t;

    state_t        r_state;
    logic [2:0]    r_pend;
    logic [3:0]    r_cnt;
    logic [2:0]    r_mod_type;
    logic          r_type_chg;
    logic          r_locked;
    logic [OW-1:0] r_demod_data;
    logic [FW-1:0] r_demod_fre;

    logic [2:0]    w_cand;
    logic [3:0]    w_cnt_nxt;
    logic          w_commit;

    // Candidate decision tree, evaluated every cycle but only consumed on meas_valid.
    always_comb begin
        w_cand = T_CW;
        if (ask_dc_offset < DC_TH_W)
            w_cand = (ask_papr > AM_PAPR_W) ? T_AM : T_ASK;
        else if (fsk_papr >= PSK_PAPR_W)
            w_cand = T_PSK;
        else if (fsk_papr >= FM_PAPR_W)
            w_cand = T_FM;
        else if (fsk_papr != 10'd0)
            w_cand = T_FSK;
    end

    always_comb begin
        w_cnt_nxt = 4'd1;
        if (w_cand == r_pend)
            w_cnt_nxt = (r_cnt >= CONF_W) ? CONF_W : r_cnt + 4'd1;
    end

    assign w_commit = (w_cnt_nxt == CONF_W);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= S_SEARCH;
            r_pend     <= T_NONE;
            r_cnt      <= 4'd0;
            r_mod_type <= T_NONE;
            r_type_chg <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_type_chg <= 1'b0;
            if (meas_valid) begin
                case (r_state)
                    S_SEARCH: begin
                        r_pend <= w_cand;
                        r_cnt  <= w_cnt_nxt;
                        if (w_commit) begin
                            r_state    <= S_TRACK;
                            r_mod_type <= w_cand;
                            r_locked   <= 1'b1;
                            r_type_chg <= 1'b1;
                        end
                    end
                    default: begin
                        // A sample matching the committed type re-arms the run at full count.
                        if (w_cand == r_mod_type) begin
                            r_state <= S_TRACK;
                            r_pend  <= r_mod_type;
                            r_cnt   <= CONF_W;
                        end else begin
                            r_pend <= w_cand;
                            r_cnt  <= w_cnt_nxt;
                            if (w_commit) begin
                                r_state    <= S_TRACK;
                                r_mod_type <= w_cand;
                                r_type_chg <= 1'b1;
                            end else begin
                                r_state <= S_CONFIRM;
                            end
                        end
                    end
                endcase
            end
        end
    end

    logic [OW-1:0] w_tr_ask, w_tr_fsk, w_tr_psk;
    logic          w_am_win;
    logic [OW-1:0] w_am;
    logic [OW-1:0] w_fm_s;
    logic [OW+1:0] w_fm_wide, w_fm_sh;
    logic [2:0]    w_fm_top;
    logic [OW-1:0] w_fm_r;
    logic [OW-1:0] w_fm;
    logic [OW-1:0] w_data_nxt;
    logic [FW-1:0] w_fre_nxt;

    assign w_tr_ask = ask_data[DW-1 -: OW];
    assign w_tr_fsk = fsk_data[DW-1 -: OW];
    assign w_tr_psk = psk_data[DW-1 -: OW];

    assign w_am_win = (ma >= MA_LO_W) && (ma <= MA_HI_W);
    assign w_am     = !w_am_win ? w_tr_ask :
                      (w_tr_ask[OW-1] ? {OW{1'b1}} : {w_tr_ask[OW-2:0], 1'b0});

    // FM: offset binary -> two's complement, widen by 2 bits, shift, clamp, back to offset binary.
    assign w_fm_s    = {~w_tr_fsk[OW-1], w_tr_fsk[OW-2:0]};
    assign w_fm_wide = {{2{w_fm_s[OW-1]}}, w_fm_s};

    always_comb begin
        w_fm_sh = w_fm_wide;
        if (fsk_freq <= F1_W)
            w_fm_sh = w_fm_wide << 2;
        else if (fsk_freq <= F2_W)
            w_fm_sh = w_fm_wide << 1;
    end

    assign w_fm_top = w_fm_sh[OW+1:OW-1];

    always_comb begin
        w_fm_r = w_fm_sh[OW-1:0];
        if (w_fm_top != 3'b000 && w_fm_top != 3'b111)
            w_fm_r = w_fm_sh[OW+1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end

    assign w_fm = {~w_fm_r[OW-1], w_fm_r[OW-2:0]};

    always_comb begin
        w_data_nxt = '0;
        w_fre_nxt  = '0;
        case (r_mod_type)
            T_AM:  begin w_data_nxt = w_am;     w_fre_nxt = ask_freq; end
            T_ASK: begin w_data_nxt = w_tr_ask; w_fre_nxt = ask_freq; end
            T_FM:  begin w_data_nxt = w_fm;     w_fre_nxt = fsk_freq; end
            T_FSK: begin w_data_nxt = w_tr_fsk; w_fre_nxt = fsk_freq; end
            T_PSK: begin w_data_nxt = w_tr_psk; w_fre_nxt = psk_freq; end
            T_CW:  begin w_data_nxt = MIDSCALE; w_fre_nxt = '0;       end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_demod_data <= '0;
            r_demod_fre  <= '0;
        end else begin
            r_demod_data <= w_data_nxt;
            r_demod_fre  <= w_fre_nxt;
        end
    end

    // Low demod bits fall away in the truncation; fold them so they are visibly consumed.
    logic w_unused;
    assign w_unused = ^{ask_data, fsk_data, psk_data};

    assign demod_data = r_demod_data;
    assign mod_type   = {5'd0, r_mod_type};
    assign demod_fre  = r_demod_fre;
    assign type_chg   = r_type_chg;
    assign locked     = r_locked;

endmodule

// File: tb/tb_mod_classify_sel.sv
// Scoreboard bench for mod_classify_sel: directed scenarios then randomized traffic,
// each cycle's expected outputs come from a run-length reference model.
module tb_mod_classify_sel;

    localparam int DW = 10;
    localparam int OW = 8;
    localparam int FW = 16;
    localparam int CONFIRM = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          meas_valid = 1'b0;
    logic [7:0]    ask_dc_offset = '0;
    logic [7:0]    ask_papr = '0;
    logic [9:0]    fsk_papr = '0;
    logic [7:0]    ma = '0;
    logic [DW-1:0] ask_data = '0, fsk_data = '0, psk_data = '0;
    logic [FW-1:0] ask_freq = '0, fsk_freq = '0, psk_freq = '0;
    logic [OW-1:0] demod_data;
    logic [7:0]    mod_type;
    logic [FW-1:0] demod_fre;
    logic          type_chg, locked;

    mod_classify_sel dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .meas_valid(meas_valid),
        .ask_dc_offset(ask_dc_offset), .ask_papr(ask_papr), .fsk_papr(fsk_papr), .ma(ma),
        .ask_data(ask_data), .fsk_data(fsk_data), .psk_data(psk_data),
        .ask_freq(ask_freq), .fsk_freq(fsk_freq), .psk_freq(psk_freq),
        .demod_data(demod_data), .mod_type(mod_type), .demod_fre(demod_fre),
        .type_chg(type_chg), .locked(locked)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  data;
        logic [7:0]  typ;
        logic [15:0] fre;
        logic        chg;
        logic        lck;
    } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: committed type plus length of the current run of identical samples.
    int m_com = 0;
    int m_rtype = 0;
    int m_run = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int cand_of();
        if (ask_dc_offset < 60) return (ask_papr > 5) ? 1 : 2;
        if (fsk_papr >= 20) return 5;
        if (fsk_papr >= 5) return 3;
        if (fsk_papr > 0) return 4;
        return 6;
    endfunction

    function automatic int dp(input int t);
        int tr_a, tr_f, tr_p, v, s;
        tr_a = int'(ask_data) / 4;
        tr_f = int'(fsk_data) / 4;
        tr_p = int'(psk_data) / 4;
        case (t)
            1: begin
                v = tr_a;
                if (ma >= 30 && ma <= 35) v = v * 2;
                return (v > 255) ? 255 : v;
            end
            2: return tr_a;
            3: begin
                s = tr_f - 128;
                if (fsk_freq <= 1500) s = s * 4;
                else if (fsk_freq <= 2500) s = s * 2;
                if (s > 127) s = 127;
                if (s < -128) s = -128;
                return s + 128;
            end
            4: return tr_f;
            5: return tr_p;
            6: return 128;
            default: return 0;
        endcase
    endfunction

    function automatic int fre_of(input int t);
        case (t)
            1, 2: return int'(ask_freq);
            3, 4: return int'(fsk_freq);
            5:    return int'(psk_freq);
            default: return 0;
        endcase
    endfunction

    task automatic step(input logic v, input logic rn);
        exp_t e;
        int prev, c;
        meas_valid = v;
        sys_rst_n = rn;
        e.cyc = cyc + 1;
        if (!rn) begin
            m_com = 0; m_rtype = 0; m_run = 0;
            e.data = 0; e.typ = 0; e.fre = 0; e.chg = 0; e.lck = 0;
        end else begin
            e.data = 8'(dp(m_com));
            e.fre = 16'(fre_of(m_com));
            prev = m_com;
            if (v) begin
                c = cand_of();
                if (c == m_rtype) m_run++;
                else begin m_rtype = c; m_run = 1; end
                if (m_run == CONFIRM && c != m_com) m_com = c;
            end
            e.typ = 8'(m_com);
            e.chg = (m_com != prev);
            e.lck = (m_com != 0);
        end
        q.push_back(e);
        @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("sb_mod_type", int'(mod_type), int'(e.typ));
            chk("sb_type_chg", int'(type_chg), int'(e.chg));
            chk("sb_locked", int'(locked), int'(e.lck));
            chk("sb_demod_data", int'(demod_data), int'(e.data));
            chk("sb_demod_fre", int'(demod_fre), int'(e.fre));
        end
    end

    task automatic set_am();  ask_dc_offset = 8'd20; ask_papr = 8'd8; endtask
    task automatic set_alt(input int fp); ask_dc_offset = 8'd80; fsk_papr = 10'(fp); endtask

    task automatic rand_meas(input int t);
        case (t)
            1: begin ask_dc_offset = 8'($urandom_range(0, 59)); ask_papr = 8'($urandom_range(6, 255)); end
            2: begin ask_dc_offset = 8'($urandom_range(0, 59)); ask_papr = 8'($urandom_range(0, 5)); end
            3: begin ask_dc_offset = 8'($urandom_range(60, 255)); fsk_papr = 10'($urandom_range(5, 19)); end
            4: begin ask_dc_offset = 8'($urandom_range(60, 255)); fsk_papr = 10'($urandom_range(1, 4)); end
            5: begin ask_dc_offset = 8'($urandom_range(60, 255)); fsk_papr = 10'($urandom_range(20, 1023)); end
            default: begin ask_dc_offset = 8'($urandom_range(60, 255)); fsk_papr = 10'd0; end
        endcase
    endtask

    initial begin
        int tgt, left;
        step(0, 0); step(0, 0); step(0, 0);
        chk("rst_mod_type", int'(mod_type), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_data", int'(demod_data), 0);

        // Power-up AM lock
        set_am(); ma = 8'd32; ask_data = 10'h0C0; ask_freq = 16'd700;
        for (int i = 0; i < 3; i++) begin step(1, 1); step(0, 1); end
        chk("am_not_yet", int'(mod_type), 0);
        step(1, 1);
        chk("am_commit", int'(mod_type), 1);
        chk("am_chg_pulse", int'(type_chg), 1);
        step(0, 1);
        chk("am_chg_clear", int'(type_chg), 0);
        chk("am_data", int'(demod_data), 'h60);
        chk("am_fre", int'(demod_fre), 700);
        ask_data = 10'h3FC; step(0, 1);
        chk("am_sat", int'(demod_data), 'hFF);
        ma = 8'd40; step(0, 1);
        chk("am_noshift", int'(demod_data), 'hFF);

        // Glitch rejection: 3 PSK samples then AM again
        set_alt(25);
        for (int i = 0; i < 3; i++) step(1, 1);
        set_am(); step(1, 1);
        set_alt(25); for (int i = 0; i < 3; i++) step(1, 1);
        chk("glitch_type", int'(mod_type), 1);

        // FM commit and scaling
        set_alt(10);
        for (int i = 0; i < 4; i++) step(1, 1);
        chk("fm_commit", int'(mod_type), 3);
        fsk_data = 10'h240; fsk_freq = 16'd1000; step(0, 1);
        chk("fm_scale", int'(demod_data), 'hC0);
        chk("fm_fre", int'(demod_fre), 1000);
        fsk_data = 10'h380; step(0, 1);
        chk("fm_sat", int'(demod_data), 'hFF);

        // CW commit, then reset mid-confirm
        set_alt(0);
        for (int i = 0; i < 4; i++) step(1, 1);
        step(0, 1);
        chk("cw_data", int'(demod_data), 'h80);
        chk("cw_fre", int'(demod_fre), 0);
        set_am(); step(1, 1); step(1, 1);
        step(1, 0);
        chk("rst2_type", int'(mod_type), 0);
        chk("rst2_data", int'(demod_data), 0);
        for (int i = 0; i < 3; i++) step(1, 1);
        chk("relock_wait", int'(mod_type), 0);
        step(1, 1);
        chk("relock", int'(mod_type), 1);

        // Random traffic with runs of the same target type
        tgt = 1; left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin tgt = $urandom_range(1, 6); left = $urandom_range(1, 7); end
            rand_meas(tgt);
            ma = 8'($urandom_range(25, 45));
            ask_data = 10'($urandom); fsk_data = 10'($urandom); psk_data = 10'($urandom);
            ask_freq = 16'($urandom); fsk_freq = 16'($urandom_range(0, 3000)); psk_freq = 16'($urandom);
            if ($urandom_range(0, 99) < 60) begin left--; step(1, ($urandom_range(0, 399) != 0)); end
            else step(0, 1);
        end

        step(0, 1);
        @(negedge sys_clk); #1;
        chk("sb_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
